// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the fetch-stage PC generator.
package pc_gen_pkg;

    // Every instruction is one 32-bit word.
    localparam int ILEN_BYTES = 4;

    // Which redirect source won the priority decision this cycle.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_TRAP = 2'd1,
        RD_JALR = 2'd2,
        RD_BR   = 2'd3
    } redirect_src_e;

    // Low-bit masks, zero-extended to XLEN at the point of use.
    localparam logic [1:0] INSN_ALIGN_MASK = 2'b11;  // cleared on trap vectors
    localparam logic [1:0] JALR_LSB_MASK   = 2'b01;  // cleared on jalr targets
    localparam logic [1:0] MISALIGN_MASK   = 2'b10;  // set => not word aligned

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator and instruction memory.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_ad;
    logic [XLEN-1:0] prev_ad;

    modport master (
        output fetch_valid,
        output fetch_ad,
        output prev_ad,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_ad,
        input  prev_ad,
        output fetch_ready
    );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with pointer and occupancy count.
// The top entry is kept in its own register so ras_top is pure state.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [XLEN-1:0] push_ad,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] top_q, top_d;
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic            is_empty;
    logic            is_full;

    assign is_empty = (cnt_q == '0);
    assign is_full  = (cnt_q == CW'(RAS_DEPTH));

    // Decode push/pop into a storage write plus next pointer, count and top.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        top_d  = top_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop && !is_empty) begin
            // Replace the current top in place.
            wr_en  = 1'b1;
            wr_idx = ptr_q - PW'(1);
            top_d  = push_ad;
        end else if (push) begin
            // When full, ptr already points at the oldest entry, so it is overwritten.
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PW'(1);
            cnt_d  = is_full ? cnt_q : cnt_q + CW'(1);
            top_d  = push_ad;
        end else if (pop && !is_empty) begin
            ptr_d  = ptr_q - PW'(1);
            cnt_d  = cnt_q - CW'(1);
            top_d  = (cnt_q > CW'(1)) ? mem[ptr_q - PW'(2)] : '0;
        end
    end

    // Stack storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_ad;
        end
    end

    // Pointer, count and cached top register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            top_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            top_q <= top_d;
        end
    end

    assign top   = top_q;
    assign empty = is_empty;
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance under valid/ready,
// prioritised redirects with misalignment rejection, and a RAS.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    pc_gen_if.master        fetch,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_base,
    input  logic [XLEN-1:0] br_offset,
    output logic            flush,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_ad,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_ad,
    input  logic            ras_pop,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
);
    localparam logic [XLEN-1:0] TRAP_KEEP = ~XLEN'(INSN_ALIGN_MASK);
    localparam logic [XLEN-1:0] JALR_KEEP = ~XLEN'(JALR_LSB_MASK);
    localparam logic [XLEN-1:0] MIS_BITS  = XLEN'(MISALIGN_MASK);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] prev_q, prev_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_ad_q, misalign_ad_d;
    redirect_src_e   src;
    logic [XLEN-1:0] tgt;
    logic            accept;
    logic            valid;

    // A request is offered in every cycle that reset is not asserted, so the
    // first post-reset cycle already presents RESET_VEC.
    assign valid  = !rst;
    assign accept = valid && fetch.fetch_ready;

    // Pick the winning redirect, then compute next PC and status pulses.
    always_comb begin
        src = RD_NONE;
        tgt = '0;
        if (trap_valid) begin
            src = RD_TRAP;
            tgt = trap_vec & TRAP_KEEP;
        end else if (jalr_valid) begin
            src = RD_JALR;
            tgt = jalr_target & JALR_KEEP;
        end else if (br_valid) begin
            src = RD_BR;
            tgt = br_base + br_offset;
        end

        pc_d          = pc_q;
        prev_d        = accept ? pc_q : prev_q;
        flush_d       = 1'b0;
        misalign_d    = 1'b0;
        misalign_ad_d = misalign_ad_q;
        if (src != RD_NONE) begin
            // Trap vectors are forced aligned, so only jalr/branch can be rejected.
            if (src != RD_TRAP && (tgt & MIS_BITS) != '0) begin
                misalign_d    = 1'b1;
                misalign_ad_d = tgt;
            end else begin
                pc_d    = tgt;
                flush_d = 1'b1;
            end
        end else if (!stall && accept) begin
            pc_d = pc_q + XLEN'(ILEN_BYTES);
        end
    end

    // PC, last-accepted address and redirect status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VEC;
            prev_q        <= RESET_VEC;
            flush_q       <= 1'b0;
            misalign_q    <= 1'b0;
            misalign_ad_q <= '0;
        end else begin
            pc_q          <= pc_d;
            prev_q        <= prev_d;
            flush_q       <= flush_d;
            misalign_q    <= misalign_d;
            misalign_ad_q <= misalign_ad_d;
        end
    end

    assign fetch.fetch_valid = valid;
    assign fetch.fetch_ad    = pc_q;
    assign fetch.prev_ad     = prev_q;
    assign flush             = flush_q;
    assign misalign          = misalign_q;
    assign misalign_ad       = misalign_ad_q;

    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (ras_push),
        .push_ad (ras_push_ad),
        .pop     (ras_pop),
        .top     (ras_top),
        .empty   (ras_empty)
    );
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen (XLEN=32, RESET_VEC=0, RAS_DEPTH=4).
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        jalr_valid;
    logic [31:0] jalr_target;
    logic        br_valid;
    logic [31:0] br_base;
    logic [31:0] br_offset;
    logic        flush;
    logic        misalign;
    logic [31:0] misalign_ad;
    logic        ras_push;
    logic [31:0] ras_push_ad;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    pc_gen_if #(.XLEN(32)) fif ();

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (fif),
        .stall       (stall),
        .trap_valid  (trap_valid),
        .trap_vec    (trap_vec),
        .jalr_valid  (jalr_valid),
        .jalr_target (jalr_target),
        .br_valid    (br_valid),
        .br_base     (br_base),
        .br_offset   (br_offset),
        .flush       (flush),
        .misalign    (misalign),
        .misalign_ad (misalign_ad),
        .ras_push    (ras_push),
        .ras_push_ad (ras_push_ad),
        .ras_pop     (ras_pop),
        .ras_top     (ras_top),
        .ras_empty   (ras_empty)
    );

    always #5 clk = ~clk;

    // Advance one edge, sample 1ns later, log the transaction.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d: v=%0b rdy=%0b ad=%h prev=%h flush=%0b mis=%0b mis_ad=%h top=%h empty=%0b",
                 cyc, fif.fetch_valid, fif.fetch_ready, fif.fetch_ad, fif.prev_ad,
                 flush, misalign, misalign_ad, ras_top, ras_empty);
    endtask

    task automatic idle_inputs();
        stall = 0; trap_valid = 0; jalr_valid = 0; br_valid = 0;
        trap_vec = 0; jalr_target = 0; br_base = 0; br_offset = 0;
        ras_push = 0; ras_pop = 0; ras_push_ad = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; fif.fetch_ready = 1;
        step(); step();
        n_cmp++; if (fif.fetch_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", fif.fetch_valid); end
        n_cmp++; if (fif.fetch_ad !== 32'h0) begin n_err++; $display("FAIL rst_ad got %h want 0", fif.fetch_ad); end
        n_cmp++; if (fif.prev_ad !== 32'h0) begin n_err++; $display("FAIL rst_prev got %h want 0", fif.prev_ad); end
        n_cmp++; if ({flush, misalign} !== 2'b00) begin n_err++; $display("FAIL rst_pulses got %b want 00", {flush, misalign}); end
        n_cmp++; if (misalign_ad !== 32'h0) begin n_err++; $display("FAIL rst_mis_ad got %h want 0", misalign_ad); end
        n_cmp++; if ({ras_empty, ras_top} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL rst_ras got empty=%0b top=%h want 1/0", ras_empty, ras_top); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_ad [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] exp_pv [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        rst = 0;
        #1;
        n_cmp++; if (fif.fetch_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid got %0b want 1", fif.fetch_valid); end
        n_cmp++; if (fif.fetch_ad !== 32'h0) begin n_err++; $display("FAIL seq_ad0 got %h want 0", fif.fetch_ad); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (fif.fetch_ad !== exp_ad[i]) begin n_err++; $display("FAIL seq_ad%0d got %h want %h", i, fif.fetch_ad, exp_ad[i]); end
            n_cmp++; if (fif.prev_ad !== exp_pv[i]) begin n_err++; $display("FAIL seq_prev%0d got %h want %h", i, fif.prev_ad, exp_pv[i]); end
        end
    endtask

    task automatic test_backpressure();
        fif.fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({fif.fetch_ad, fif.prev_ad} !== {32'h10, 32'hC}) begin n_err++; $display("FAIL hold%0d got ad=%h prev=%h want 10/c", i, fif.fetch_ad, fif.prev_ad); end
        end
        br_valid = 1; br_base = 32'h10; br_offset = 32'hFFFF_FFF0;
        step();
        br_valid = 0;
        n_cmp++; if ({fif.fetch_ad, flush} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL br_redirect got ad=%h flush=%0b want 0/1", fif.fetch_ad, flush); end
        n_cmp++; if (fif.prev_ad !== 32'hC) begin n_err++; $display("FAIL br_prev got %h want c", fif.prev_ad); end
        step();
        n_cmp++; if ({fif.fetch_ad, flush} !== {32'h0, 1'b0}) begin n_err++; $display("FAIL br_after got ad=%h flush=%0b want 0/0", fif.fetch_ad, flush); end
        // Stall holds even while memory is ready.
        stall = 1; fif.fetch_ready = 1;
        step();
        stall = 0; fif.fetch_ready = 0;
        n_cmp++; if ({fif.fetch_ad, fif.prev_ad} !== {32'h0, 32'h0}) begin n_err++; $display("FAIL stall got ad=%h prev=%h want 0/0", fif.fetch_ad, fif.prev_ad); end
    endtask

    task automatic test_priority();
        trap_valid = 1; trap_vec = 32'h103;
        jalr_valid = 1; jalr_target = 32'h200;
        br_valid = 1; br_base = 32'h40; br_offset = 32'h0;
        step();
        idle_inputs();
        n_cmp++; if ({fif.fetch_ad, flush} !== {32'h100, 1'b1}) begin n_err++; $display("FAIL prio got ad=%h flush=%0b want 100/1", fif.fetch_ad, flush); end
        jalr_valid = 1; jalr_target = 32'h201; br_valid = 1; br_base = 32'h40;
        step();
        idle_inputs();
        n_cmp++; if (fif.fetch_ad !== 32'h200) begin n_err++; $display("FAIL jalr_lsb got %h want 200", fif.fetch_ad); end
        trap_valid = 1; trap_vec = 32'h100;
        step();
        idle_inputs();
        step();
        n_cmp++; if ({fif.fetch_ad, flush} !== {32'h100, 1'b0}) begin n_err++; $display("FAIL flush_len got ad=%h flush=%0b want 100/0", fif.fetch_ad, flush); end
    endtask

    task automatic test_misalign();
        fif.fetch_ready = 1;
        jalr_valid = 1; jalr_target = 32'h203;
        step();
        idle_inputs(); fif.fetch_ready = 0;
        n_cmp++; if ({misalign, flush} !== 2'b10) begin n_err++; $display("FAIL mis_pulse got mis=%0b flush=%0b want 1/0", misalign, flush); end
        n_cmp++; if (misalign_ad !== 32'h202) begin n_err++; $display("FAIL mis_ad got %h want 202", misalign_ad); end
        n_cmp++; if (fif.fetch_ad !== 32'h100) begin n_err++; $display("FAIL mis_pc got %h want 100", fif.fetch_ad); end
        step();
        n_cmp++; if ({misalign, misalign_ad} !== {1'b0, 32'h202}) begin n_err++; $display("FAIL mis_hold got mis=%0b ad=%h want 0/202", misalign, misalign_ad); end
        br_valid = 1; br_base = 32'h100; br_offset = 32'h6;
        step();
        idle_inputs();
        n_cmp++; if ({misalign, misalign_ad, fif.fetch_ad} !== {1'b1, 32'h106, 32'h100}) begin n_err++; $display("FAIL br_mis got mis=%0b ad=%h pc=%h want 1/106/100", misalign, misalign_ad, fif.fetch_ad); end
    endtask

    task automatic test_wrap();
        jalr_valid = 1; jalr_target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        n_cmp++; if (fif.fetch_ad !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_set got %h want fffffffc", fif.fetch_ad); end
        fif.fetch_ready = 1;
        step();
        fif.fetch_ready = 0;
        n_cmp++; if ({fif.fetch_ad, fif.prev_ad} !== {32'h0, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_inc got ad=%h prev=%h want 0/fffffffc", fif.fetch_ad, fif.prev_ad); end
        br_valid = 1; br_base = 32'hFFFF_FFF0; br_offset = 32'h20;
        step();
        idle_inputs();
        n_cmp++; if (fif.fetch_ad !== 32'h10) begin n_err++; $display("FAIL wrap_br got %h want 10", fif.fetch_ad); end
    endtask

    task automatic test_ras();
        logic [31:0] pushes [5] = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE};
        logic [31:0] pop_top [4] = '{32'hD, 32'hC, 32'hB, 32'h0};
        logic        pop_emp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            ras_push = 1; ras_push_ad = pushes[i];
            step();
        end
        ras_push = 0;
        n_cmp++; if ({ras_top, ras_empty} !== {32'hE, 1'b0}) begin n_err++; $display("FAIL ras_full got top=%h empty=%0b want e/0", ras_top, ras_empty); end
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1;
            step();
            n_cmp++; if ({ras_top, ras_empty} !== {pop_top[i], pop_emp[i]}) begin n_err++; $display("FAIL ras_pop%0d got top=%h empty=%0b want %h/%0b", i, ras_top, ras_empty, pop_top[i], pop_emp[i]); end
        end
        step();
        ras_pop = 0;
        n_cmp++; if ({ras_top, ras_empty} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL ras_pop_empty got top=%h empty=%0b want 0/1", ras_top, ras_empty); end
        ras_push = 1; ras_push_ad = 32'hE;
        step();
        ras_pop = 1; ras_push_ad = 32'h5;
        step();
        n_cmp++; if ({ras_top, ras_empty} !== {32'h5, 1'b0}) begin n_err++; $display("FAIL ras_replace got top=%h empty=%0b want 5/0", ras_top, ras_empty); end
        ras_push = 0;
        step();
        ras_pop = 0;
        n_cmp++; if ({ras_top, ras_empty} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL ras_count got top=%h empty=%0b want 0/1", ras_top, ras_empty); end
        ras_push = 1; ras_pop = 1; ras_push_ad = 32'h7;
        step();
        ras_pop = 0; ras_push_ad = 32'h9;
        step();
        ras_push = 0; ras_pop = 1;
        step();
        ras_pop = 0;
        n_cmp++; if ({ras_top, ras_empty} !== {32'h7, 1'b0}) begin n_err++; $display("FAIL ras_pp_empty got top=%h empty=%0b want 7/0", ras_top, ras_empty); end
        ras_push = 1; ras_push_ad = 32'h33; rst = 1;
        step();
        idle_inputs(); rst = 0;
        n_cmp++; if ({ras_top, ras_empty} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL ras_rst got top=%h empty=%0b want 0/1", ras_top, ras_empty); end
        n_cmp++; if (fif.fetch_ad !== 32'h0) begin n_err++; $display("FAIL rst_mid_pc got %h want 0", fif.fetch_ad); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_priority();
        test_misalign();
        test_wrap();
        test_ras();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
